hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Decode-stage hazard unit and destination-register tracker for the 5-stage MIPS pipeline.
- Carries each instruction's write-back destination through E/M/W and drives the WriteReg/RegWrite signals that the forwarding unit and register file consume.
- Detects hazards that forwarding cannot cover: load-use, branch-compare dependency, and multi-cycle multiply/divide busy.
- For each such hazard it stalls F/D and inserts a bubble into E.

Parameters:
MULT_LATENCY, 4, cycles the mult/div unit stays busy after an accepted start (1 .. 2^CNT_W-1)
CNT_W, 3, width of the busy counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
RsD  in  5  source register rs of instruction in D
RtD  in  5  source register rt of instruction in D
WriteRegD  in  5  destination register of instruction in D (rd/rt already selected)
RegWriteD  in  1  instruction in D writes the register file
MemtoRegD  in  1  instruction in D is a load
BranchD  in  1  instruction in D is a branch compared in D
MultStartD  in  1  instruction in D starts mult/div
MfHiLoD  in  1  instruction in D reads HI/LO
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushE  out  1  bubble into ID/EX
WriteRegE  out  5  destination tracked in E
WriteRegM  out  5  destination tracked in M
WriteRegW  out  5  destination tracked in W
RegWriteE  out  1  E-stage write enable
RegWriteM  out  1  M-stage write enable
RegWriteW  out  1  W-stage write enable
MemtoRegE  out  1  E-stage load flag
MultBusy  out  1  mult/div counter non-zero

Behaviour:
- Reset (rst_n=0, asynchronous): E/M/W fields (WriteReg, RegWrite, MemtoReg) cleared to 0, busy counter cleared to 0.
  - All outputs are therefore 0 during and immediately after reset.
  - Reset taking effect mid-mult/div drops MultBusy in the same cycle.
- Pipeline tracking, every rising edge:
  - E <= D fields, unless FlushE is asserted. On FlushE, E <= bubble (WriteReg=0, RegWrite=0, MemtoReg=0).
  - M <= E and W <= M unconditionally; this block never stalls E/M/W.
- match(x) = RegWrite_x && WriteReg_x != 0 && (WriteReg_x == RsD || WriteReg_x == RtD).
- lwstall = MemtoRegE && match(E).
- branchstall = BranchD && (match(E) || (MemtoRegM && match(M))).
  - Requires an internal MemtoRegM register, pipelined from MemtoRegE.
- mdstall = MultBusy && (MfHiLoD || MultStartD).
- stall = lwstall | branchstall | mdstall. StallF = StallD = FlushE = stall. These outputs are combinational from current state and D inputs; no added latency.
- Register $0 never causes a stall. A destination of 0 with RegWrite=1 is treated as no write for hazard purposes, but is still tracked and output unchanged.
- Busy counter:
  - If MultStartD && !stall: count <= MULT_LATENCY.
  - Else if count != 0: count <= count - 1.
  - MultBusy = (count != 0).
  - A start is accepted only when not stalled. A start blocked by lwstall is accepted in the first unstalled cycle.
  - Counter reaching 0 releases a waiting MfHiLoD in that same cycle.
- Simultaneous hazards OR together; there is no priority encoding.
- A stall lasts exactly as long as its condition holds:
  - A load-use stall lasts 1 cycle, because the bubble moves the load to M.
  - A branch depending on a load stalls 2 cycles.
  - A branch depending on an ALU op in E stalls 1 cycle.

Test Plan:
- Reset: rst_n=0 mid-operation with count=3 -> all outputs 0 asynchronously; after release, no stall with any D inputs except the MultStartD path.
- Load-use: load $8 (MemtoRegD=1, RegWriteD=1, WriteRegD=8), then D holds RsD=8:
  - Cycle 1: stall=1 and next-cycle RegWriteE=0.
  - Cycle 2: stall=0, and WriteRegM=8 appears one cycle after the load leaves E.
- Branch after ALU/load: add $9 then beq RsD=9 -> exactly 1 stall cycle. lw $9 then beq RtD=9 -> exactly 2 stall cycles.
- $0 immunity: load to $0 followed by RsD=0, and branch on $0 after an ALU write to $0 -> stall never asserts.
- Mult/div: MultStartD pulse with MULT_LATENCY=4, then MfHiLoD held -> MultBusy=1 for 4 cycles, stall=1 for those 4 cycles, released when count hits 0. A second MultStartD while busy also stalls.
- Combined: lwstall and mdstall asserted together -> single stall. MultStartD held during lwstall -> counter loads only on the first unstalled cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detection and E/M/W destination tracking.
// Stalls F/D and bubbles E on load-use, branch and mult/div hazards.
module hazard_scoreboard #(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_W        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] WriteRegD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       BranchD,
  input  logic       MultStartD,
  input  logic       MfHiLoD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic [4:0] WriteRegE,
  output logic [4:0] WriteRegM,
  output logic [4:0] WriteRegW,
  output logic       RegWriteE,
  output logic       RegWriteM,
  output logic       RegWriteW,
  output logic       MemtoRegE,
  output logic       MultBusy
);

  typedef struct packed {
    logic [4:0] wreg;
    logic       rwr;
    logic       m2r;
  } dst_t;

  localparam logic [CNT_W-1:0] LAT =
    CNT_W'(MULT_LATENCY);

  dst_t             d_s;
  dst_t             e_q;
  dst_t             m_q;
  dst_t             w_q;
  logic [CNT_W-1:0] cnt_q;

  logic hit_e;
  logic hit_m;
  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;

  // $0 is never a real producer, so it cannot create a dependency.
  function automatic logic hit(
    input dst_t       s,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return s.rwr && (s.wreg != 5'd0) &&
           ((s.wreg == rs) || (s.wreg == rt));
  endfunction

  // Hazard terms are OR-ed; each lasts only while its cause holds.
  always_comb begin
    d_s      = '{wreg: WriteRegD,
                 rwr:  RegWriteD,
                 m2r:  MemtoRegD};
    hit_e    = hit(e_q, RsD, RtD);
    hit_m    = hit(m_q, RsD, RtD);
    MultBusy = (cnt_q != '0);
    lwstall  = e_q.m2r && hit_e;
    brstall  = BranchD &&
               (hit_e || (m_q.m2r && hit_m));
    mdstall  = MultBusy &&
               (MfHiLoD || MultStartD);
    stall    = lwstall | brstall | mdstall;
  end

  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushE    = stall;
  assign WriteRegE = e_q.wreg;
  assign WriteRegM = m_q.wreg;
  assign WriteRegW = w_q.wreg;
  assign RegWriteE = e_q.rwr;
  assign RegWriteM = m_q.rwr;
  assign RegWriteW = w_q.rwr;
  assign MemtoRegE = e_q.m2r;

  // E takes D or a bubble; M and W always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= stall ? dst_t'('0) : d_s;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  // Busy counter loads only on an unstalled start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (MultStartD && !stall) begin
      cnt_q <= LAT;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Expected vectors are queued by stimulus, checked by a monitor.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] RsD, RtD, WriteRegD;
  logic       RegWriteD, MemtoRegD, BranchD;
  logic       MultStartD, MfHiLoD;
  logic       StallF, StallD, FlushE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MultBusy;

  logic [22:0] expq[$];
  int checks = 0;
  int errors = 0;
  int vecn   = 0;

  hazard_scoreboard #(
    .MULT_LATENCY(4),
    .CNT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD),
    .WriteRegD(WriteRegD),
    .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD),
    .BranchD(BranchD),
    .MultStartD(MultStartD),
    .MfHiLoD(MfHiLoD),
    .StallF(StallF), .StallD(StallD),
    .FlushE(FlushE),
    .WriteRegE(WriteRegE),
    .WriteRegM(WriteRegM),
    .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .MultBusy(MultBusy)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] mk(
    input logic st,
    input logic [4:0] wre,
    input logic [4:0] wrm,
    input logic [4:0] wrw,
    input logic rwe, input logic rwm,
    input logic rww, input logic m2re,
    input logic busy
  );
    return {st, st, st, wre, wrm, wrw,
            rwe, rwm, rww, m2re, busy};
  endfunction

  task automatic drive(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] wr, input logic rw,
    input logic m2r, input logic br,
    input logic ms, input logic mf
  );
    RsD = rs; RtD = rt; WriteRegD = wr;
    RegWriteD = rw; MemtoRegD = m2r;
    BranchD = br; MultStartD = ms;
    MfHiLoD = mf;
  endtask

  task automatic cyc(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] wr, input logic rw,
    input logic m2r, input logic br,
    input logic ms, input logic mf,
    input logic [22:0] ex
  );
    @(posedge clk);
    #1;
    drive(rs, rt, wr, rw, m2r, br, ms, mf);
    expq.push_back(ex);
  endtask

  // Outputs sampled mid-cycle against the oldest queued vector.
  always @(negedge clk) begin
    logic [22:0] act;
    logic [22:0] ex;
    if (expq.size() != 0) begin
      ex  = expq.pop_front();
      act = {StallF, StallD, FlushE,
             WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW,
             MemtoRegE, MultBusy};
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h",
                 vecn, act, ex);
      end
      vecn++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    logic [22:0] z;
    z = '0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expq.push_back(z);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, z);
    // load-use on $8
    cyc(2, 0, 8, 1, 1, 0, 0, 0, z);
    cyc(8, 3, 10, 1, 0, 0, 0, 0,
        mk(1, 8, 0, 0, 1, 0, 0, 1, 0));
    cyc(8, 3, 10, 1, 0, 0, 0, 0,
        mk(0, 0, 8, 0, 0, 1, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 10, 0, 8, 1, 0, 1, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 0, 10, 0, 0, 1, 0, 0, 0));
    // branch after ALU: one stall
    cyc(1, 2, 9, 1, 0, 0, 0, 0,
        mk(0, 0, 0, 10, 0, 0, 1, 0, 0));
    cyc(9, 0, 0, 0, 0, 1, 0, 0,
        mk(1, 9, 0, 0, 1, 0, 0, 0, 0));
    cyc(9, 0, 0, 0, 0, 1, 0, 0,
        mk(0, 0, 9, 0, 0, 1, 0, 0, 0));
    // branch after load: two stalls
    cyc(1, 0, 9, 1, 1, 0, 0, 0,
        mk(0, 0, 0, 9, 0, 0, 1, 0, 0));
    cyc(4, 9, 0, 0, 0, 1, 0, 0,
        mk(1, 9, 0, 0, 1, 0, 0, 1, 0));
    cyc(4, 9, 0, 0, 0, 1, 0, 0,
        mk(1, 0, 9, 0, 0, 1, 0, 0, 0));
    cyc(4, 9, 0, 0, 0, 1, 0, 0,
        mk(0, 0, 0, 9, 0, 0, 1, 0, 0));
    // $0 immunity
    cyc(1, 0, 0, 1, 1, 0, 0, 0, z);
    cyc(0, 0, 0, 1, 0, 0, 0, 0,
        mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
    cyc(0, 0, 0, 0, 0, 1, 0, 0,
        mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    // mult start then mfhi held
    cyc(1, 2, 0, 0, 0, 0, 1, 0, z);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 3, 1, 0, 0, 0, 1,
          mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(0, 0, 3, 1, 0, 0, 0, 1, z);
    // second start while busy
    cyc(1, 2, 0, 0, 0, 0, 1, 0,
        mk(0, 3, 0, 0, 1, 0, 0, 0, 0));
    cyc(1, 2, 0, 0, 0, 0, 1, 0,
        mk(1, 0, 3, 0, 0, 1, 0, 0, 1));
    // async reset with count at 3
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    expq.push_back(z);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(8, 9, 0, 0, 0, 1, 0, 1, z);
    // lwstall and mdstall together
    cyc(1, 2, 0, 0, 0, 0, 1, 0, z);
    cyc(1, 2, 8, 1, 1, 0, 0, 0,
        mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(8, 0, 4, 1, 0, 0, 0, 1,
        mk(1, 8, 0, 0, 1, 0, 0, 1, 1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 0, 8, 0, 0, 1, 0, 0, 1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 0, 0, 8, 0, 0, 1, 0, 1));
    // start held across a load-use stall
    cyc(1, 2, 7, 1, 1, 0, 0, 0, z);
    cyc(7, 0, 0, 0, 0, 0, 1, 0,
        mk(1, 7, 0, 0, 1, 0, 0, 1, 0));
    cyc(7, 0, 0, 0, 0, 0, 1, 0,
        mk(0, 0, 7, 0, 0, 1, 0, 0, 0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 0, 0, 7, 0, 0, 1, 0, 1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0,
        mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, expected 0",
               expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
